instr_fetch: RTL and testbench
==============================

# instr_fetch

Multicycle instruction-fetch stage feeding the immediate sign-extender and the main control FSM. It owns the 64-bit PC and issues single-word requests to instruction memory over a req/valid handshake. It latches the returned word into the instruction register (IR) and presents the whole word plus decoded fields downstream. It supports stall, consumer acknowledge and branch/jump redirect with discard of in-flight responses.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permit new fetches.
- stall  in  1  freeze IR handoff; blocks ir_ack.
- ir_ack  in  1  consumer has taken the IR contents.
- pc_load  in  1  redirect request, one-cycle pulse.
- pc_next  in  64  redirect target (branch/jump).
- imem_req  out  1  memory request strobe, one cycle per fetch.
- imem_addr  out  64  fetch address, valid while imem_req=1.
- imem_valid  in  1  response strobe; meaningful only in WAIT.
- imem_rdata  in  32  instruction word, valid with imem_valid.
- ir  out  32  latched instruction; drives sign-extender `entrada`.
- ir6_0  out  7  ir[6:0]; drives sign-extender `IR6_0`.
- rd, rs1, rs2  out  5 each  ir[11:7], ir[19:15], ir[24:20].
- funct3  out  3  ir[14:12].
- funct7  out  7  ir[31:25].
- ir_valid  out  1  IR holds an unconsumed instruction.
- pc_ir  out  64  address the IR word was fetched from.
- fetch_misalign  out  1  sticky flag: last pc_next had bits [1:0] != 0.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- IDLE: if fetch_en=1, go to REQ. Otherwise stay in IDLE.
- REQ: imem_req=1 and imem_addr=pc for exactly one cycle, then go to WAIT unconditionally.
- WAIT: imem_req=0. On imem_valid=1 there are two cases:
  - flush=0: ir<=imem_rdata, pc_ir<=pc, pc<=pc+4, go to HOLD.
  - flush=1: discard the data, clear flush, go to REQ if fetch_en=1, else IDLE.
  - Latency is unbounded; the block waits indefinitely.
- HOLD: ir_valid=1. If ir_ack=1 and stall=0, go to REQ if fetch_en=1, else IDLE. Otherwise stay in HOLD with IR stable.
- Redirect (pc_load=1). In every state, pc<=pc_next with bits [1:0] forced to 0, and fetch_misalign<=|pc_next[1:0]. Per state:
  - IDLE: remain in IDLE.
  - REQ: the request is already issued; set flush and go to WAIT.
  - WAIT with imem_valid=0: set flush and stay in WAIT.
  - WAIT with imem_valid=1 in the same cycle: discard the data and go to REQ, or IDLE if fetch_en=0.
  - HOLD: drop the IR (ir_valid falls) and go to REQ, or IDLE if fetch_en=0. pc_load wins over a simultaneous ir_ack.
- imem_valid outside WAIT is ignored.
- pc+4 wraps modulo 2^64.
- Field outputs are combinational slices of the ir register.
- ir_valid = (state==HOLD).

## Timing
- Reset values (asynchronous, immediate on reset_n=0):
  - pc=RESET_PC, pc_ir=RESET_PC.
  - ir=32'h00000013 (ADDI x0,x0,0), so ir6_0=7'b0010011 and rd/rs1/rs2/funct3/funct7=0.
  - ir_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_misalign=0, flush=0, state=IDLE.
- Reset mid-fetch abandons any outstanding request. A late imem_valid after reset is ignored because the state is IDLE.
- Minimum latency:
  - fetch_en sampled at edge E0 → imem_req high in cycle E0..E1.
  - Earliest imem_valid is sampled at E2 → ir_valid=1 from E2.
- Throughput is at most one instruction per 3 cycles: ack at edge En → REQ → imem_req in cycle En..En+1.
- IR, pc_ir and all fields are stable for the entire time ir_valid=1.

## Test plan
- Reset release, fetch_en=1, memory latency 1, imem_rdata=32'h00500093 (addi x1,x0,5).
  - Required: imem_addr=0 with a single-cycle req; ir_valid rises 2 edges after req; ir6_0=7'h13, rd=1, rs1=0, pc_ir=0; next request addr=4.
- Hold with stall=1 and ir_ack=1 for 5 cycles, then stall=0.
  - Required: IR constant and no imem_req during the stall; REQ follows the first unstalled ack.
- pc_load with pc_next=64'h100 during WAIT; the old response (32'hDEADBEEF) arrives 3 cycles later.
  - Required: the data is discarded and ir is unchanged; the next imem_addr=64'h100; the following IR carries pc_ir=64'h100.
- pc_load with pc_next=64'h202 in the same cycle as ir_ack in HOLD.
  - Required: ir_valid=0 next cycle; fetch_misalign=1; the next imem_addr=64'h200.
- pc=64'hFFFF_FFFF_FFFF_FFFC and a fetch completes.
  - Required: pc wraps to 0 and the next imem_addr=0.
- Assert reset_n=0 in WAIT, release, then pulse imem_valid.
  - Required: ir=32'h00000013, ir_valid=0, and the pulse is ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// Multicycle instruction-fetch stage: owns the PC, issues single-word imem requests,
// latches the returned word into the IR and presents decoded fields downstream.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        ir_ack,
  input  logic        pc_load,
  input  logic [63:0] pc_next,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [6:0]  ir6_0,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        ir_valid,
  output logic [63:0] pc_ir,
  output logic        fetch_misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state, state_nx;
  logic [63:0] pc;
  logic        flush;
  logic        accept;
  logic [63:0] redirect_pc;

  // A response is kept only if it belongs to the current PC stream and no redirect lands with it.
  assign accept      = (state == WAIT) && imem_valid && !flush && !pc_load;
  assign redirect_pc = {pc_next[63:2], 2'b00};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (fetch_en && !pc_load) state_nx = REQ;
      REQ:  state_nx = WAIT;
      WAIT: if (imem_valid) state_nx = accept ? HOLD : (fetch_en ? REQ : IDLE);
      HOLD: if (pc_load || (ir_ack && !stall)) state_nx = fetch_en ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      pc_ir          <= RESET_PC;
      ir             <= NOP;
      flush          <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      state <= state_nx;

      if (pc_load) begin
        pc             <= redirect_pc;
        fetch_misalign <= |pc_next[1:0];
      end else if (accept) begin
        pc <= pc + 64'd4;
      end

      if (accept) begin
        ir    <= imem_rdata;
        pc_ir <= pc;
      end

      // The in-flight response is consumed either way; a redirect before it arrives marks it stale.
      if ((state == WAIT) && imem_valid)
        flush <= 1'b0;
      else if (pc_load && ((state == REQ) || (state == WAIT)))
        flush <= 1'b1;
    end
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign ir_valid  = (state == HOLD);

  assign ir6_0  = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en, stall, ir_ack, pc_load, imem_valid;
  logic [63:0] pc_next;
  logic [31:0] imem_rdata;
  logic        imem_req, ir_valid, fetch_misalign;
  logic [63:0] imem_addr, pc_ir;
  logic [31:0] ir;
  logic [6:0]  ir6_0, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .stall(stall), .ir_ack(ir_ack),
    .pc_load(pc_load), .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .ir(ir), .ir6_0(ir6_0), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .ir_valid(ir_valid),
    .pc_ir(pc_ir), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fe, st, ack, pl;
    logic [63:0] pn;
    logic        vld;
    logic [31:0] rdat;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_irv;
    logic [31:0] e_ir;
    logic [63:0] e_pcir;
    logic        e_mis;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [63:0] e_addr,
                           input logic e_irv, input logic [31:0] e_ir,
                           input logic [63:0] e_pcir, input logic e_mis);
    check({tag, ".req"}, 64'(imem_req), 64'(e_req));
    if (e_req) check({tag, ".addr"}, imem_addr, e_addr);
    check({tag, ".ir_valid"}, 64'(ir_valid), 64'(e_irv));
    check({tag, ".ir"}, 64'(ir), 64'(e_ir));
    check({tag, ".fields"}, 64'({funct7, rs2, rs1, funct3, rd, ir6_0}), 64'(e_ir));
    check({tag, ".pc_ir"}, pc_ir, e_pcir);
    check({tag, ".misalign"}, 64'(fetch_misalign), 64'(e_mis));
  endtask

  task automatic drive(input logic fe, input logic st, input logic ack, input logic pl,
                       input logic [63:0] pn, input logic vld, input logic [31:0] rdat);
    fetch_en = fe; stall = st; ir_ack = ack; pc_load = pl;
    pc_next = pn; imem_valid = vld; imem_rdata = rdat;
  endtask

  task automatic step(input logic fe, input logic st, input logic ack, input logic pl,
                      input logic [63:0] pn, input logic vld, input logic [31:0] rdat);
    drive(fe, st, ack, pl, pn, vld, rdat);
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks the fetch as a transaction (request issued, response
  // outstanding, response stale, instruction held) rather than as an FSM encoding.
  logic        m_issuing, m_outstanding, m_stale, m_holding, m_mis;
  logic [63:0] m_pc, m_pc_ir;
  logic [31:0] m_ir;

  task automatic model_reset();
    m_issuing = 0; m_outstanding = 0; m_stale = 0; m_holding = 0; m_mis = 0;
    m_pc = 64'h0; m_pc_ir = 64'h0; m_ir = 32'h0000_0013;
  endtask

  task automatic model_step();
    if (m_issuing) begin
      m_issuing     = 0;
      m_outstanding = 1;
      if (pc_load) m_stale = 1;
    end else if (m_outstanding) begin
      if (imem_valid) begin
        m_outstanding = 0;
        if (!m_stale && !pc_load) begin
          m_ir      = imem_rdata;
          m_pc_ir   = m_pc;
          m_pc      = m_pc + 64'd4;
          m_holding = 1;
        end else begin
          m_stale   = 0;
          m_issuing = fetch_en;
        end
      end else if (pc_load) begin
        m_stale = 1;
      end
    end else if (m_holding) begin
      if (pc_load || (ir_ack && !stall)) begin
        m_holding = 0;
        m_issuing = fetch_en;
      end
    end else begin
      m_issuing = fetch_en && !pc_load;
    end
    if (pc_load) begin
      m_pc  = pc_next & ~64'h3;
      m_mis = (pc_next[1:0] != 2'b00);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //         fe  st  ack pl  pn        vld rdat          req addr     irv ir            pc_ir    mis
    tbl[0]  = '{1, 0, 0, 0, 64'h0,    0, 32'h0,        1, 64'h0,   0, 32'h0000_0013, 64'h0,   0};
    tbl[1]  = '{1, 0, 0, 0, 64'h0,    0, 32'h0,        0, 64'h0,   0, 32'h0000_0013, 64'h0,   0};
    tbl[2]  = '{1, 0, 0, 0, 64'h0,    1, 32'h0050_0093, 0, 64'h0,  1, 32'h0050_0093, 64'h0,   0};
    tbl[3]  = '{1, 0, 0, 0, 64'h0,    0, 32'h0,        0, 64'h0,   1, 32'h0050_0093, 64'h0,   0};
    for (int i = 4; i <= 8; i++)
      tbl[i] = '{1, 1, 1, 0, 64'h0,   0, 32'h0,        0, 64'h0,   1, 32'h0050_0093, 64'h0,   0};
    tbl[9]  = '{1, 0, 1, 0, 64'h0,    0, 32'h0,        1, 64'h4,   0, 32'h0050_0093, 64'h0,   0};
    tbl[10] = '{1, 0, 0, 0, 64'h0,    0, 32'h0,        0, 64'h0,   0, 32'h0050_0093, 64'h0,   0};
    tbl[11] = '{1, 0, 0, 1, 64'h100,  0, 32'h0,        0, 64'h0,   0, 32'h0050_0093, 64'h0,   0};
    tbl[12] = '{1, 0, 0, 0, 64'h0,    0, 32'h0,        0, 64'h0,   0, 32'h0050_0093, 64'h0,   0};
    tbl[13] = '{1, 0, 0, 0, 64'h0,    0, 32'h0,        0, 64'h0,   0, 32'h0050_0093, 64'h0,   0};
    tbl[14] = '{1, 0, 0, 0, 64'h0,    1, 32'hDEAD_BEEF, 1, 64'h100, 0, 32'h0050_0093, 64'h0,  0};
    tbl[15] = '{1, 0, 0, 0, 64'h0,    0, 32'h0,        0, 64'h0,   0, 32'h0050_0093, 64'h0,   0};
    tbl[16] = '{1, 0, 0, 0, 64'h0,    1, 32'h00A0_0113, 0, 64'h0,  1, 32'h00A0_0113, 64'h100, 0};
    tbl[17] = '{1, 0, 1, 1, 64'h202,  0, 32'h0,        1, 64'h200, 0, 32'h00A0_0113, 64'h100, 1};
    tbl[18] = '{1, 0, 0, 0, 64'h0,    0, 32'h0,        0, 64'h0,   0, 32'h00A0_0113, 64'h100, 1};
    tbl[19] = '{1, 0, 0, 0, 64'h0,    1, 32'h0020_81B3, 0, 64'h0,  1, 32'h0020_81B3, 64'h200, 1};
    tbl[20] = '{0, 0, 1, 0, 64'h0,    0, 32'h0,        0, 64'h0,   0, 32'h0020_81B3, 64'h200, 1};
    tbl[21] = '{0, 0, 0, 0, 64'h0,    1, 32'hFFFF_FFFF, 0, 64'h0,  0, 32'h0020_81B3, 64'h200, 1};

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 64'h0, 1'b0, 32'h0000_0013, 64'h0, 1'b0);
    check("reset.addr", imem_addr, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].fe, tbl[i].st, tbl[i].ack, tbl[i].pl, tbl[i].pn, tbl[i].vld, tbl[i].rdat);
      check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_irv,
                tbl[i].e_ir, tbl[i].e_pcir, tbl[i].e_mis);
    end

    // PC wrap: redirect to the last word of the address space, fetch it, then fetch again.
    step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0);
    check_all("wrap.load", 1'b0, 64'h0, 1'b0, 32'h0020_81B3, 64'h200, 1'b0);
    step(1, 0, 0, 0, 64'h0, 0, 32'h0);
    check_all("wrap.req", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0020_81B3, 64'h200, 1'b0);
    step(1, 0, 0, 0, 64'h0, 0, 32'h0);
    step(1, 0, 0, 0, 64'h0, 1, 32'h0000_0093);
    check_all("wrap.hold", 1'b0, 64'h0, 1'b1, 32'h0000_0093, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    step(1, 0, 1, 0, 64'h0, 0, 32'h0);
    check_all("wrap.next", 1'b1, 64'h0, 1'b0, 32'h0000_0093, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

    // Reset while a response is outstanding, then a late response pulse.
    step(1, 0, 0, 0, 64'h0, 0, 32'h0);
    reset_n = 1'b0;
    #1;
    check_all("rst_wait", 1'b0, 64'h0, 1'b0, 32'h0000_0013, 64'h0, 1'b0);
    check("rst_wait.addr", imem_addr, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 64'h0, 1, 32'h1234_5678);
    check_all("rst_late", 1'b0, 64'h0, 1'b0, 32'h0000_0013, 64'h0, 1'b0);

    // Randomized traffic against the reference model.
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      fetch_en   = ($urandom_range(9) < 8);
      stall      = ($urandom_range(3) == 0);
      ir_ack     = ($urandom_range(1) == 1);
      pc_load    = ($urandom_range(9) == 0);
      pc_next    = {$urandom(), $urandom()};
      if ($urandom_range(3) == 0) pc_next[63:4] = '1;
      imem_valid = ($urandom_range(2) == 0);
      imem_rdata = $urandom();
      @(posedge clk);
      model_step();
      #1;
      check_all($sformatf("rand%0d", cyc), m_issuing, m_pc, m_holding, m_ir, m_pc_ir, m_mis);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
